// File: rtl/reg_bank_arbiter_pkg.sv
// Shared register-bank types, dimensions and named register indices.
package regPKG;

    localparam int REG_ADDRWIDTH = 4;
    localparam int REG_DATAWIDTH = 16;
    localparam int NUM_REGS      = 16;

    typedef logic [REG_ADDRWIDTH-1:0] reg_addr_t;
    typedef logic [REG_DATAWIDTH-1:0] reg_data_t;
    typedef reg_data_t [NUM_REGS-1:0] reg_bank_t;

    localparam logic [NUM_REGS-1:0] REG_RO_MASK_DEFAULT = 16'h0000;

    localparam reg_addr_t REG0 = 4'd0;
    localparam reg_addr_t REG1 = 4'd1;
    localparam reg_addr_t REG2 = 4'd2;
    localparam reg_addr_t REG3 = 4'd3;
    localparam reg_addr_t REG4 = 4'd4;

endpackage

// File: rtl/reg_bank_arbiter_rr_arbiter.sv
// One-hot request arbiter; REG_BANK_ARB_ROUND_ROBIN_EN selects round-robin,
// otherwise fixed priority with the lowest index winning.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] ptr_nxt_s;

    // Search the request vector starting at the pointer, wrapping once.
    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_r) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!found && req[IDX_W'(idx)]) begin
                found                = 1'b1;
                grant[IDX_W'(idx)]   = 1'b1;
                grant_idx            = IDX_W'(idx);
            end else begin
                found = found;
            end
        end
    end

`ifdef REG_BANK_ARB_ROUND_ROBIN_EN
    // Pointer moves just past the winner so it has lowest priority next time.
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (advance) begin
            if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
                ptr_nxt_s = '0;
            end else begin
                ptr_nxt_s = grant_idx + IDX_W'(1);
            end
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end
`else
    logic unused_advance_s;
    assign unused_advance_s = advance;

    // Fixed priority: the pointer stays at zero.
    always_comb begin
        ptr_nxt_s = '0;
    end
`endif

    // Priority pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// 16x16 control register bank shared by NUM_REQ bus requesters plus a hardware
// status port. Arbitration mode follows REG_BANK_ARB_ROUND_ROBIN_EN (see rr_arbiter).
module reg_bank_arbiter
    import regPKG::*;
#(
    parameter int                  NUM_REQ = 2,
    parameter logic [NUM_REGS-1:0] RO_MASK = REG_RO_MASK_DEFAULT,
    parameter reg_bank_t           RST_VAL = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0]                   req_write,
    input  logic [NUM_REQ-1:0][REG_ADDRWIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0][REG_DATAWIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic                                 rsp_err,
    output logic [REG_DATAWIDTH-1:0]             rsp_rdata,
    input  logic                                 hw_we,
    input  logic [REG_ADDRWIDTH-1:0]             hw_addr,
    input  logic [REG_DATAWIDTH-1:0]             hw_wdata,
    output reg_bank_t                            regs_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] arb_grant_s;
    logic [IDX_W-1:0]   arb_idx_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic               any_gnt_s;
    logic               sel_write_s;
    reg_addr_t          sel_addr_s;
    reg_data_t          sel_wdata_s;
    logic               ro_hit_s;
    logic               collide_s;
    logic               bus_wr_ok_s;
    logic               rsp_err_nxt_s;
    reg_data_t          rsp_rdata_nxt_s;

    reg_bank_t          bank_r;
    logic [NUM_REQ-1:0] rsp_valid_r;
    logic               rsp_err_r;
    reg_data_t          rsp_rdata_r;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (any_gnt_s),
        .grant     (arb_grant_s),
        .grant_idx (arb_idx_s)
    );

    // Grant qualification and access checks for the selected requester.
    always_comb begin
        gnt_s           = '0;
        sel_write_s     = req_write[arb_idx_s];
        sel_addr_s      = req_addr[arb_idx_s];
        sel_wdata_s     = req_wdata[arb_idx_s];
        if (rst) begin
            gnt_s = '0;
        end else begin
            gnt_s = arb_grant_s;
        end
        any_gnt_s       = |gnt_s;
        ro_hit_s        = RO_MASK[sel_addr_s];
        collide_s       = hw_we && (hw_addr == sel_addr_s);
        bus_wr_ok_s     = any_gnt_s && sel_write_s && !ro_hit_s && !collide_s;
        rsp_err_nxt_s   = any_gnt_s && sel_write_s && (ro_hit_s || collide_s);
        rsp_rdata_nxt_s = '0;
        if (any_gnt_s && !sel_write_s) begin
            rsp_rdata_nxt_s = bank_r[sel_addr_s];
        end else begin
            rsp_rdata_nxt_s = '0;
        end
    end

    // Register bank; the hw port is applied last so it wins any collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_r <= RST_VAL;
        end else begin
            if (bus_wr_ok_s) begin
                bank_r[sel_addr_s] <= sel_wdata_s;
            end
            if (hw_we) begin
                bank_r[hw_addr] <= hw_wdata;
            end
        end
    end

    // One-cycle response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= '0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= '0;
        end else begin
            rsp_valid_r <= gnt_s;
            rsp_err_r   <= rsp_err_nxt_s;
            rsp_rdata_r <= rsp_rdata_nxt_s;
        end
    end

    // A response falling in a reset cycle is suppressed.
    assign rsp_valid = rsp_valid_r & {NUM_REQ{~rst}};
    assign req_ready = gnt_s;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;
    assign regs_o    = bank_r;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed, table-driven bench for reg_bank_arbiter (2 requesters, reg 15 read-only).
module tb_reg_bank_arbiter;
    import regPKG::*;

    localparam reg_bank_t TB_RST = {
        16'h100F, 16'h100E, 16'h100D, 16'h100C, 16'h100B, 16'h100A, 16'h1009, 16'h1008,
        16'h1007, 16'h1006, 16'h1005, 16'h1004, 16'h1003, 16'h1002, 16'h1001, 16'h1000
    };

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           req_valid;
    logic [1:0]           req_write;
    logic [1:0][3:0]      req_addr;
    logic [1:0][15:0]     req_wdata;
    logic [1:0]           req_ready;
    logic [1:0]           rsp_valid;
    logic                 rsp_err;
    logic [15:0]          rsp_rdata;
    logic                 hw_we;
    logic [3:0]           hw_addr;
    logic [15:0]          hw_wdata;
    reg_bank_t            regs_o;

    int n_chk  = 0;
    int n_fail = 0;

    reg_bank_arbiter #(
        .NUM_REQ (2),
        .RO_MASK (16'h8000),
        .RST_VAL (TB_RST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .hw_we     (hw_we),
        .hw_addr   (hw_addr),
        .hw_wdata  (hw_wdata),
        .regs_o    (regs_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  write;
        logic [3:0]  addr0;
        logic [3:0]  addr1;
        logic [15:0] wd0;
        logic [15:0] wd1;
        logic        hwe;
        logic [3:0]  hwa;
        logic [15:0] hwd;
        logic [1:0]  exp_ready;
        logic        exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        req_valid = 2'b00;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        hw_we     = 1'b0;
        hw_addr   = 4'd0;
        hw_wdata  = 16'h0000;
    endtask

    initial begin
        logic [1:0] exp_g;

        //               valid  write  a0     a1     wd0       wd1       hwe   hwa    hwd       rdy    err   rdata
        vecs[0]  = '{2'b01, 2'b01, 4'd5,  4'd0,  16'h1234, 16'h0000, 1'b0, 4'd0,  16'h0000, 2'b01, 1'b0, 16'h0000};
        vecs[1]  = '{2'b01, 2'b00, 4'd5,  4'd0,  16'h0000, 16'h0000, 1'b0, 4'd0,  16'h0000, 2'b01, 1'b0, 16'h1234};
        vecs[2]  = '{2'b10, 2'b10, 4'd0,  4'd15, 16'h0000, 16'hFFFF, 1'b0, 4'd0,  16'h0000, 2'b10, 1'b1, 16'h0000};
        vecs[3]  = '{2'b10, 2'b00, 4'd0,  4'd15, 16'h0000, 16'h0000, 1'b0, 4'd0,  16'h0000, 2'b10, 1'b0, 16'h100F};
        vecs[4]  = '{2'b01, 2'b01, 4'd2,  4'd0,  16'h5555, 16'h0000, 1'b1, 4'd2,  16'h00AA, 2'b01, 1'b1, 16'h0000};
        vecs[5]  = '{2'b01, 2'b00, 4'd2,  4'd0,  16'h0000, 16'h0000, 1'b0, 4'd0,  16'h0000, 2'b01, 1'b0, 16'h00AA};
        vecs[6]  = '{2'b01, 2'b01, 4'd2,  4'd0,  16'h5555, 16'h0000, 1'b1, 4'd4,  16'h00BB, 2'b01, 1'b0, 16'h0000};
        vecs[7]  = '{2'b10, 2'b00, 4'd0,  4'd2,  16'h0000, 16'h0000, 1'b0, 4'd0,  16'h0000, 2'b10, 1'b0, 16'h5555};
        vecs[8]  = '{2'b01, 2'b00, 4'd4,  4'd0,  16'h0000, 16'h0000, 1'b0, 4'd0,  16'h0000, 2'b01, 1'b0, 16'h00BB};
        vecs[9]  = '{2'b00, 2'b00, 4'd0,  4'd0,  16'h0000, 16'h0000, 1'b1, 4'd7,  16'h0042, 2'b00, 1'b0, 16'h0000};
        vecs[10] = '{2'b10, 2'b00, 4'd0,  4'd7,  16'h0000, 16'h0000, 1'b0, 4'd0,  16'h0000, 2'b10, 1'b0, 16'h0042};
        vecs[11] = '{2'b01, 2'b00, 4'd0,  4'd0,  16'h0000, 16'h0000, 1'b0, 4'd0,  16'h0000, 2'b01, 1'b0, 16'h1000};
        vecs[12] = '{2'b01, 2'b00, 4'd5,  4'd0,  16'h0000, 16'h0000, 1'b1, 4'd5,  16'h9999, 2'b01, 1'b0, 16'h1234};
        vecs[13] = '{2'b01, 2'b00, 4'd5,  4'd0,  16'h0000, 16'h0000, 1'b0, 4'd0,  16'h0000, 2'b01, 1'b0, 16'h9999};

        // Power-on reset, with requests pending to show ready is held low.
        rst = 1'b1;
        idle();
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("ready_in_reset", 32'(req_ready), 32'h0);
        rst = 1'b0;
        idle();
        #1;
        chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset rsp_err", 32'(rsp_err), 32'h0);
        chk("reset rsp_rdata", 32'(rsp_rdata), 32'h0);
        for (int r = 0; r < 16; r++) begin
            chk($sformatf("reset regs_o[%0d]", r), 32'(regs_o[r]), 32'h1000 + 32'(r));
        end

        // Contention: both requesters read for four cycles.
        @(negedge clk);
        req_valid   = 2'b11;
        req_write   = 2'b00;
        req_addr[0] = 4'd0;
        req_addr[1] = 4'd1;
        for (int c = 0; c < 4; c++) begin
`ifdef REG_BANK_ARB_ROUND_ROBIN_EN
            exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            #1;
            chk($sformatf("contend%0d ready", c), 32'(req_ready), 32'(exp_g));
            @(posedge clk);
            #1;
            chk($sformatf("contend%0d rsp_valid", c), 32'(rsp_valid), 32'(exp_g));
            chk($sformatf("contend%0d rdata", c), 32'(rsp_rdata),
                (exp_g == 2'b01) ? 32'h1000 : 32'h1001);
            @(negedge clk);
        end
        idle();

        // Table-driven single-access vectors.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            req_valid    = vecs[i].valid;
            req_write    = vecs[i].write;
            req_addr[0]  = vecs[i].addr0;
            req_addr[1]  = vecs[i].addr1;
            req_wdata[0] = vecs[i].wd0;
            req_wdata[1] = vecs[i].wd1;
            hw_we        = vecs[i].hwe;
            hw_addr      = vecs[i].hwa;
            hw_wdata     = vecs[i].hwd;
            #1;
            chk($sformatf("vec%0d ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_ready));
            if (vecs[i].exp_ready != 2'b00) begin
                chk($sformatf("vec%0d rsp_err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
                chk($sformatf("vec%0d rsp_rdata", i), 32'(rsp_rdata), 32'(vecs[i].exp_rdata));
            end
        end
        #1;
        chk("ro reg15 unchanged", 32'(regs_o[15]), 32'h100F);
        chk("collision reg2 final", 32'(regs_o[2]), 32'h5555);
        chk("hw reg4", 32'(regs_o[4]), 32'h00BB);

        // Reset after a completed write restores the reset value.
        @(negedge clk);
        idle();
        req_valid    = 2'b01;
        req_write    = 2'b01;
        req_addr[0]  = 4'd3;
        req_wdata[0] = 16'hABCD;
        @(posedge clk);
        #1;
        chk("pre-reset reg3", 32'(regs_o[3]), 32'hABCD);
        @(negedge clk);
        rst       = 1'b1;
        req_write = 2'b00;
        #1;
        chk("rst ready", 32'(req_ready), 32'h0);
        chk("rst rsp suppressed", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1;
        chk("post-rst reg3", 32'(regs_o[3]), 32'h1003);
        chk("post-rst rsp_valid", 32'(rsp_valid), 32'h0);

        // Reset in the grant cycle of a write discards it.
        @(negedge clk);
        rst          = 1'b1;
        req_valid    = 2'b01;
        req_write    = 2'b01;
        req_addr[0]  = 4'd1;
        req_wdata[0] = 16'h7777;
        #1;
        chk("midrst ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        chk("midrst rsp_valid", 32'(rsp_valid), 32'h0);
        chk("midrst reg1", 32'(regs_o[1]), 32'h1001);
        @(posedge clk);
        #1;
        chk("midrst rsp_valid late", 32'(rsp_valid), 32'h0);
        chk("midrst reg1 late", 32'(regs_o[1]), 32'h1001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
